// File: rtl/hermes_tx_framer_pkg.sv
// Shared DMNI definitions: Hermes framing states and flit-position constants.
package DMNIPkg;

  // Position of a flit within a Hermes packet as seen by a framing tracker.
  typedef enum logic [1:0] {
    FRAME_HEADER  = 2'd0,
    FRAME_SIZE    = 2'd1,
    FRAME_PAYLOAD = 2'd2
  } frame_state_t;

  // The flit right after the header carries the payload length.
  localparam int HERMES_SIZE_FLIT_IDX = 1;

endpackage

// File: rtl/hermes_tx_framer_frame.sv
// Hermes packet framing tracker: follows header/size/payload positions of a flit
// stream and flags the last flit of each packet.
module hermes_frame_tracker
  import DMNIPkg::*;
#(
  parameter int FLIT_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 xfer_i,
  input  logic [FLIT_SIZE-1:0] flit_i,
  output logic [1:0]           state_o,
  output logic                 eop_o
);

  frame_state_t         state;
  logic [FLIT_SIZE-1:0] remaining;

  assign state_o = state;

  // Last flit: a zero size flit, or the final payload flit; only on a real transfer.
  always_comb begin
    eop_o = 1'b0;
    if (xfer_i) begin
      if (state == FRAME_SIZE && flit_i == '0)
        eop_o = 1'b1;
      else if (state == FRAME_PAYLOAD && remaining == FLIT_SIZE'(1))
        eop_o = 1'b1;
    end
  end

  // Framing FSM, advanced once per transferred flit; payload contents are never inspected.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= FRAME_HEADER;
      remaining <= '0;
    end else if (xfer_i) begin
      case (state)
        FRAME_HEADER: state <= FRAME_SIZE;
        FRAME_SIZE: begin
          remaining <= flit_i;
          state     <= (flit_i == '0) ? FRAME_HEADER : FRAME_PAYLOAD;
        end
        FRAME_PAYLOAD: begin
          remaining <= remaining - FLIT_SIZE'(1);
          if (remaining == FLIT_SIZE'(1))
            state <= FRAME_HEADER;
        end
        default: state <= FRAME_HEADER;
      endcase
    end
  end

endmodule

// File: rtl/hermes_tx_framer.sv
// Output staging between the DMNI Hermes interface and the router local port:
// credit-based FIFO plus packet framing monitors (in-packet, sent pulse/count, idle).
module hermes_tx_framer
  import DMNIPkg::*;
#(
  parameter int HERMES_FLIT_SIZE = 32,
  parameter int BUFFER_SIZE      = 8,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        dmni_tx_i,
  output logic                        dmni_credit_o,
  input  logic [HERMES_FLIT_SIZE-1:0] dmni_data_i,
  output logic                        noc_tx_o,
  input  logic                        noc_credit_i,
  output logic [HERMES_FLIT_SIZE-1:0] noc_data_o,
  input  logic                        cnt_clr_i,
  output logic                        in_pkt_o,
  output logic                        pkt_sent_o,
  output logic [CNT_WIDTH-1:0]        pkt_count_o,
  output logic                        idle_o
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int OCC_W = PTR_W + 1;

  logic [HERMES_FLIT_SIZE-1:0] mem [BUFFER_SIZE];
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic [OCC_W-1:0]            occupancy;

  logic       push;
  logic       pop;
  logic [1:0] in_state;
  logic [1:0] out_state;
  logic       in_eop_unused;
  logic       out_eop;

  // Credit and valid come purely from registered occupancy, so a full FIFO
  // refuses a push even in a cycle where the router drains a flit.
  assign dmni_credit_o = (occupancy != OCC_W'(BUFFER_SIZE));
  assign noc_tx_o      = (occupancy != '0);
  assign noc_data_o    = mem[rd_ptr];

  assign push = dmni_tx_i && dmni_credit_o;
  assign pop  = noc_tx_o && noc_credit_i;

  assign in_pkt_o = (in_state != FRAME_HEADER);
  assign idle_o   = (occupancy == '0) && (in_state == FRAME_HEADER) &&
                    (out_state == FRAME_HEADER);

  // Flit storage; contents need no reset because occupancy gates their visibility.
  always_ff @(posedge clk_i) begin
    if (push)
      mem[wr_ptr] <= dmni_data_i;
  end

  // Pointers wrap naturally; occupancy distinguishes full from empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        occupancy <= occupancy + OCC_W'(1);
      else if (pop && !push)
        occupancy <= occupancy - OCC_W'(1);
    end
  end

  hermes_frame_tracker #(
    .FLIT_SIZE (HERMES_FLIT_SIZE)
  ) u_in_tracker (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .xfer_i  (push),
    .flit_i  (dmni_data_i),
    .state_o (in_state),
    .eop_o   (in_eop_unused)
  );

  hermes_frame_tracker #(
    .FLIT_SIZE (HERMES_FLIT_SIZE)
  ) u_out_tracker (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .xfer_i  (pop),
    .flit_i  (noc_data_o),
    .state_o (out_state),
    .eop_o   (out_eop)
  );

  // Completion pulse and wrapping packet counter; a coincident clear wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pkt_sent_o  <= 1'b0;
      pkt_count_o <= '0;
    end else begin
      pkt_sent_o <= pop && out_eop;
      if (cnt_clr_i)
        pkt_count_o <= '0;
      else if (pop && out_eop)
        pkt_count_o <= pkt_count_o + CNT_WIDTH'(1);
    end
  end

endmodule
